// File: rtl/seat_table_ctrl.sv
// Seat-reservation table: per-seat owner/stamp/state, student command FSM,
// manager config port and a background sweeper that auto-returns stale AWAY seats.
module seat_table_ctrl #(
    parameter  int N_SEATS       = 32,
    parameter  int SID_W         = 32,
    parameter  int TIME_W        = 11,
    parameter  int DEFAULT_LIMIT = 60,
    localparam int SEAT_W        = $clog2(N_SEATS)
) (
    input  logic              clk_mem,
    input  logic              rst_n_mem,
    input  logic [TIME_W-1:0] now_mem,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SID_W-1:0]  cmd_sid,
    input  logic [SEAT_W-1:0] cmd_seat,
    input  logic [1:0]        cmd_state,
    output logic              rsp_valid,
    output logic [2:0]        rsp_code,
    input  logic              cfg_valid,
    input  logic              cfg_op,
    input  logic [1:0]        cfg_ban,
    input  logic [TIME_W-1:0] cfg_limit,
    output logic              ret_valid,
    output logic [SEAT_W-1:0] ret_seat,
    output logic [SID_W-1:0]  ret_sid,
    input  logic [SEAT_W-1:0] rd_seat,
    output logic [1:0]        rd_state,
    output logic [SID_W-1:0]  rd_sid,
    output logic [SEAT_W:0]   occ_count
);

    localparam logic [1:0] S_FREE = 2'd0;
    localparam logic [1:0] S_AWAY = 2'd1;
    localparam logic [1:0] S_OCC  = 2'd2;
    localparam logic [1:0] S_BAN  = 2'd3;

    localparam logic [2:0] R_CHANGED  = 3'd0;
    localparam logic [2:0] R_CHECKOUT = 3'd1;
    localparam logic [2:0] R_BANNED   = 3'd2;
    localparam logic [2:0] R_NOCHANGE = 3'd3;
    localparam logic [2:0] R_OWNER    = 3'd4;
    localparam logic [2:0] R_OTHER    = 3'd5;
    localparam logic [2:0] R_ILLEGAL  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} fsm_e;

    logic [SID_W-1:0]  sid_reg   [N_SEATS];
    logic [TIME_W-1:0] stamp_reg [N_SEATS];
    logic [1:0]        state_reg [N_SEATS];

    logic [TIME_W-1:0] limit_reg;
    fsm_e              fsm_reg, fsm_next;
    logic [SID_W-1:0]  req_sid_reg;
    logic [SEAT_W-1:0] req_seat_reg;
    logic [1:0]        req_state_reg;
    logic [2:0]        rsp_code_reg;
    logic [SEAT_W-1:0] sweep_ptr_reg;
    logic              ret_valid_reg;
    logic [SEAT_W-1:0] ret_seat_reg;
    logic [SID_W-1:0]  ret_sid_reg;
    logic [SEAT_W:0]   occ_reg, occ_next;

    logic [N_SEATS-1:0] owns_other;
    logic [N_SEATS-1:0] ban_hit;
    logic [N_SEATS-1:0] busy;

    logic              cfg_ban_apply;
    logic              cfg_lim_apply;
    logic              exec_go;
    logic              exec_write;
    logic              exec_clear;
    logic [2:0]        exec_code;
    logic [1:0]        cur_state;
    logic [SID_W-1:0]  cur_sid;
    logic              sweep_hold;
    logic              sweep_ret;
    logic [TIME_W-1:0] elapsed;

    assign cfg_ban_apply = cfg_valid && !cfg_op && (cfg_ban != 2'd3);
    assign cfg_lim_apply = cfg_valid && cfg_op;

    // Per-seat parallel comparators: ownership elsewhere, ban parity, occupancy.
    generate
        for (genvar gi = 0; gi < N_SEATS; gi++) begin : g_seat
            localparam logic PARITY = 1'(gi % 2);
            assign owns_other[gi] = (sid_reg[gi] == req_sid_reg) &&
                                    (req_seat_reg != SEAT_W'(gi));
            assign ban_hit[gi]    = !cfg_ban[1] && (cfg_ban[0] == PARITY);
            assign busy[gi]       = (state_reg[gi] == S_AWAY) || (state_reg[gi] == S_OCC);
        end
    endgenerate

    assign cur_state = state_reg[req_seat_reg];
    assign cur_sid   = sid_reg[req_seat_reg];

    always_comb begin
        exec_code  = R_CHANGED;
        exec_write = 1'b0;
        exec_clear = 1'b0;
        if (req_sid_reg == '0 || req_state_reg == S_BAN) begin
            exec_code = R_ILLEGAL;
        end else if (cur_state == S_BAN) begin
            exec_code = R_BANNED;
        end else if (req_state_reg == cur_state) begin
            exec_code = R_NOCHANGE;
        end else if (cur_sid != '0 && cur_sid != req_sid_reg) begin
            exec_code = R_OWNER;
        end else if (|owns_other) begin
            exec_code = R_OTHER;
        end else if (req_state_reg == S_AWAY && cur_state == S_FREE) begin
            exec_code = R_ILLEGAL;
        end else if (req_state_reg == S_FREE) begin
            exec_code  = R_CHECKOUT;
            exec_write = 1'b1;
            exec_clear = 1'b1;
        end else begin
            exec_write = 1'b1;
        end
    end

    // A config strobe during EXEC stalls evaluation so it sees the updated table.
    always_comb begin
        fsm_next  = fsm_reg;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        exec_go   = 1'b0;
        case (fsm_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) fsm_next = EXEC;
            end
            EXEC: begin
                if (!cfg_valid) begin
                    exec_go  = 1'b1;
                    fsm_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                fsm_next  = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign sweep_hold = cfg_valid || (fsm_reg == EXEC && req_seat_reg == sweep_ptr_reg);
    assign elapsed    = now_mem - stamp_reg[sweep_ptr_reg];
    assign sweep_ret  = !sweep_hold && (state_reg[sweep_ptr_reg] == S_AWAY) &&
                        (limit_reg != '0) && (elapsed >= limit_reg);

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < N_SEATS; i++) begin
            occ_next = occ_next + (SEAT_W+1)'(busy[i]);
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n_mem) begin
        if (!rst_n_mem) begin
            for (int i = 0; i < N_SEATS; i++) begin
                sid_reg[i]   <= '0;
                stamp_reg[i] <= '0;
                state_reg[i] <= S_FREE;
            end
        end else begin
            for (int i = 0; i < N_SEATS; i++) begin
                if (cfg_ban_apply) begin
                    if (ban_hit[i]) begin
                        sid_reg[i]   <= '0;
                        stamp_reg[i] <= '0;
                        state_reg[i] <= S_BAN;
                    end else if (state_reg[i] == S_BAN) begin
                        state_reg[i] <= S_FREE;
                    end
                end else if (exec_go && exec_write && req_seat_reg == SEAT_W'(i)) begin
                    sid_reg[i]   <= exec_clear ? '0 : req_sid_reg;
                    stamp_reg[i] <= exec_clear ? '0 : now_mem;
                    state_reg[i] <= req_state_reg;
                end else if (sweep_ret && sweep_ptr_reg == SEAT_W'(i)) begin
                    sid_reg[i]   <= '0;
                    stamp_reg[i] <= '0;
                    state_reg[i] <= S_FREE;
                end
            end
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n_mem) begin
        if (!rst_n_mem) begin
            limit_reg     <= TIME_W'(DEFAULT_LIMIT);
            fsm_reg       <= IDLE;
            req_sid_reg   <= '0;
            req_seat_reg  <= '0;
            req_state_reg <= '0;
            rsp_code_reg  <= '0;
            sweep_ptr_reg <= '0;
            ret_valid_reg <= 1'b0;
            ret_seat_reg  <= '0;
            ret_sid_reg   <= '0;
            occ_reg       <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            occ_reg       <= occ_next;
            ret_valid_reg <= sweep_ret;
            if (cfg_lim_apply) limit_reg <= cfg_limit;
            if (cmd_valid && cmd_ready) begin
                req_sid_reg   <= cmd_sid;
                req_seat_reg  <= cmd_seat;
                req_state_reg <= cmd_state;
            end
            if (exec_go) rsp_code_reg <= exec_code;
            if (sweep_ret) begin
                ret_seat_reg <= sweep_ptr_reg;
                ret_sid_reg  <= sid_reg[sweep_ptr_reg];
            end
            if (!sweep_hold) begin
                sweep_ptr_reg <= (sweep_ptr_reg == SEAT_W'(N_SEATS-1)) ? '0
                                                                       : sweep_ptr_reg + SEAT_W'(1);
            end
        end
    end

    assign rsp_code  = rsp_code_reg;
    assign ret_valid = ret_valid_reg;
    assign ret_seat  = ret_seat_reg;
    assign ret_sid   = ret_sid_reg;
    assign occ_count = occ_reg;
    assign rd_state  = state_reg[rd_seat];
    assign rd_sid    = sid_reg[rd_seat];

endmodule
